// File: rtl/fft_stream_if.sv
// Stream and fft-core signal bundle for fft_stream_ctrl.
// The slave modport is the controller view; master is the host/fft side.
interface fft_stream_if #(
  parameter int width = 16,
  parameter int N_2   = 5
);
  logic                 s_valid;
  logic                 s_ready;
  logic [width-1:0]     s_data;
  logic                 fft_load;
  logic                 fft_start;
  logic [width-1:0]     fft_rd;
  logic [2*width-1:0]   fft_wd;
  logic                 fft_done;
  logic                 m_valid;
  logic                 m_ready;
  logic [2*width-1:0]   m_data;
  logic [N_2-1:0]       m_idx;
  logic                 m_last;
  logic                 busy;
  logic                 err;

  modport master (
    output s_valid, s_data, fft_wd, fft_done, m_ready,
    input  s_ready, fft_load, fft_start, fft_rd, m_valid, m_data, m_idx, m_last, busy, err
  );

  modport slave (
    input  s_valid, s_data, fft_wd, fft_done, m_ready,
    output s_ready, fft_load, fft_start, fft_rd, m_valid, m_data, m_idx, m_last, busy, err
  );
endinterface

// File: rtl/fft_stream_ctrl.sv
// Frame controller for the fft core: fill ibuf, burst-load, start, capture bins, drain.
// Optional WAIT watchdog when FFT_CTRL_TIMEOUT_EN is defined (parameter TIMEOUT).
//
// state   | meaning
// FILL    | accept 2**N_2 input samples into ibuf
// LOAD    | replay ibuf to the fft, one sample per cycle
// START   | single fft_start pulse
// WAIT    | wait for the first cycle of fft_done
// CAPTURE | store bins into obuf while fft_done is high
// DRAIN   | present obuf in bin order on the output stream
module fft_stream_ctrl #(
  parameter int width = 16,
  parameter int N_2   = 5
`ifdef FFT_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input logic         clk,
  input logic         reset,
  fft_stream_if.slave bus
);
  localparam int N = 1 << N_2;
  localparam logic [N_2:0] LAST = (N_2+1)'(N - 1);

  localparam logic [2:0] FILL    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] START   = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;
  localparam logic [2:0] DRAIN   = 3'd5;

  logic [2:0]         state;
  logic [N_2:0]       cnt;
  logic [N_2:0]       cnt_nxt;
  logic [N_2-1:0]     idx;
  logic [N_2-1:0]     idx_nxt;
  logic               at_last;
  logic [width-1:0]   ibuf [N];
  logic [2*width-1:0] obuf [N];

  logic               s_ready_q;
  logic               load_q;
  logic               start_q;
  logic [width-1:0]   rd_q;
  logic               m_valid_q;
  logic [2*width-1:0] m_data_q;
  logic [N_2-1:0]     m_idx_q;
  logic               m_last_q;

  assign cnt_nxt = cnt + 1'b1;
  assign idx     = cnt[N_2-1:0];
  assign idx_nxt = cnt_nxt[N_2-1:0];
  assign at_last = (cnt == LAST);

  // Buffers carry no reset: a frame is only ever read after being fully written.
  always_ff @(posedge clk) begin
    if (state == FILL && bus.s_valid && s_ready_q)
      ibuf[idx] <= bus.s_data;
    if ((state == WAIT || state == CAPTURE) && bus.fft_done)
      obuf[idx] <= bus.fft_wd;
  end

`ifdef FFT_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdog;
  logic            err_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      cnt       <= '0;
      s_ready_q <= 1'b1;
      load_q    <= 1'b0;
      start_q   <= 1'b0;
      rd_q      <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_idx_q   <= '0;
      m_last_q  <= 1'b0;
`ifdef FFT_CTRL_TIMEOUT_EN
      wdog      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        FILL: begin
          if (bus.s_valid && s_ready_q) begin
            if (at_last) begin
              // ibuf[0] was written on an earlier cycle, so it can be presented right away.
              cnt       <= '0;
              s_ready_q <= 1'b0;
              load_q    <= 1'b1;
              rd_q      <= ibuf[0];
              state     <= LOAD;
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end
        LOAD: begin
          if (at_last) begin
            cnt     <= '0;
            load_q  <= 1'b0;
            rd_q    <= '0;
            start_q <= 1'b1;
            state   <= START;
          end else begin
            cnt  <= cnt_nxt;
            rd_q <= ibuf[idx_nxt];
          end
        end
        START: begin
          start_q <= 1'b0;
          state   <= WAIT;
`ifdef FFT_CTRL_TIMEOUT_EN
          wdog    <= '0;
`endif
        end
        WAIT: begin
          if (bus.fft_done) begin
            cnt   <= cnt_nxt;
            state <= CAPTURE;
          end else begin
`ifdef FFT_CTRL_TIMEOUT_EN
            if (wdog == WD_W'(TIMEOUT - 1)) begin
              err_q     <= 1'b1;
              cnt       <= '0;
              s_ready_q <= 1'b1;
              state     <= FILL;
            end else begin
              wdog <= wdog + 1'b1;
            end
`endif
          end
        end
        CAPTURE: begin
          if (bus.fft_done) begin
            if (at_last) begin
              cnt       <= '0;
              m_valid_q <= 1'b1;
              m_data_q  <= obuf[0];
              m_idx_q   <= '0;
              m_last_q  <= 1'b0;
              state     <= DRAIN;
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end
        DRAIN: begin
          if (bus.m_ready) begin
            if (m_last_q) begin
              cnt       <= '0;
              m_valid_q <= 1'b0;
              m_data_q  <= '0;
              m_idx_q   <= '0;
              m_last_q  <= 1'b0;
              s_ready_q <= 1'b1;
              state     <= FILL;
            end else begin
              cnt      <= cnt_nxt;
              m_data_q <= obuf[idx_nxt];
              m_idx_q  <= idx_nxt;
              m_last_q <= (cnt_nxt == LAST);
            end
          end
        end
        default: begin
          cnt       <= '0;
          s_ready_q <= 1'b1;
          state     <= FILL;
        end
      endcase
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.fft_load  = load_q;
  assign bus.fft_start = start_q;
  assign bus.fft_rd    = rd_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_idx     = m_idx_q;
  assign bus.m_last    = m_last_q;
  assign bus.busy      = (state != FILL);
`ifdef FFT_CTRL_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif
endmodule
